// File: rtl/control_unit_seq.sv
// Registered ID-stage control unit: decodes a 5-bit opcode into the ID/EX control
// word one cycle later and sequences branch resolution and multi-cycle multiplies.
module control_unit_seq #(
    parameter int MULT_CYCLES   = 3,
    parameter int ALU_W         = 4,
    parameter bit FLUSH_ON_JUMP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       opcode_i,
    input  logic             valid_i,
    input  logic [1:0]       flags_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             illegal_o,
    output logic [1:0]       pc_sel_o,
    output logic             sel_dir_reg_b_o,
    output logic             mux_val_a_o,
    output logic             mux_val_b_o,
    output logic [ALU_W-1:0] alu_code_o,
    output logic [1:0]       result_sel_o,
    output logic             dir_write_sel_o,
    output logic             dir_mem_sel_o,
    output logic             dato_sel_o,
    output logic             mem_we_o,
    output logic             reg_we_o
);

    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) + 1 : 1;

    typedef enum logic [1:0] {RUN, BR_RESOLVE, BR_OUT, MUL_BUSY} stateT;

    typedef struct packed {
        logic [1:0]       pcSel;
        logic             selDirRegB;
        logic             valA;
        logic             valB;
        logic [ALU_W-1:0] alu;
        logic [1:0]       resultSel;
        logic             dirWrite;
        logic             dirMem;
        logic             dato;
        logic             memWe;
        logic             regWe;
        logic             flush;
        logic             illegal;
    } ctrlWordT;

    localparam ctrlWordT NOP_ZERO = '{dirMem: 1'b1, default: '0};

    stateT      stateReg, stateNext;
    logic [CNT_W-1:0] countReg, countNext;
    ctrlWordT   wordReg, wordNext, decWord;
    logic       brEqReg, brEqNext;
    logic       isAluOp;
    logic [3:0] aluSel;
    logic       accept;
    logic       taken;

    // Pure opcode decode; sequencing decisions are layered on top below.
    always_comb begin
        decWord = NOP_ZERO;
        isAluOp = 1'b1;
        aluSel  = 4'b0000;
        case (opcode_i)
            5'b00000, 5'b00001: aluSel = 4'b0011;
            5'b00010, 5'b00011: aluSel = 4'b0100;
            5'b00100, 5'b00101: aluSel = 4'b0101;
            5'b00110:           aluSel = 4'b0000;
            5'b00111:           aluSel = 4'b0001;
            5'b01000:           aluSel = 4'b0110;
            5'b01001:           aluSel = 4'b0010;
            5'b10000:           aluSel = 4'b0111;
            5'b10001:           aluSel = 4'b1001;
            5'b10010:           aluSel = 4'b1010;
            default:            isAluOp = 1'b0;
        endcase
        if (isAluOp) begin
            decWord.alu       = ALU_W'(aluSel);
            decWord.resultSel = 2'b10;
            decWord.dato      = 1'b1;
            decWord.regWe     = 1'b1;
            decWord.valB      = (opcode_i == 5'b00001) || (opcode_i == 5'b00011) ||
                                (opcode_i == 5'b00101);
        end else begin
            case (opcode_i)
                5'b01010, 5'b01011: begin
                    decWord.dirMem    = 1'b0;
                    decWord.resultSel = 2'b11;
                    decWord.regWe     = 1'b1;
                    decWord.valA      = opcode_i[0];
                end
                5'b01100, 5'b01101: begin
                    decWord.selDirRegB = 1'b1;
                    decWord.memWe      = 1'b1;
                    decWord.valA       = opcode_i[0];
                end
                5'b01110, 5'b01111: begin
                    decWord.dato  = 1'b1;
                    decWord.regWe = 1'b1;
                    decWord.valA  = opcode_i[0];
                end
                5'b10011: begin
                    decWord.dirMem = 1'b0;
                    decWord.pcSel  = 2'b01;
                    decWord.flush  = FLUSH_ON_JUMP;
                end
                5'b10100, 5'b10101: begin
                    decWord.selDirRegB = 1'b1;
                    decWord.alu        = ALU_W'(4'b0101);
                    decWord.dato       = 1'b1;
                end
                5'b10110: begin
                    decWord.alu       = ALU_W'(4'b1000);
                    decWord.resultSel = 2'b01;
                    decWord.dirWrite  = 1'b1;
                    decWord.dato      = 1'b1;
                    // A single-cycle multiply writes back from its only output cycle.
                    decWord.regWe     = (MULT_CYCLES == 1);
                end
                5'b10111: begin
                    decWord.resultSel = 2'b11;
                    decWord.dirWrite  = 1'b1;
                    decWord.dato      = 1'b1;
                end
                default: decWord.illegal = 1'b1;
            endcase
        end
    end

    assign stall_o = (stateReg == BR_RESOLVE) || (stateReg == MUL_BUSY);
    assign flush_o = wordReg.flush;
    assign accept  = valid_i && !stall_o && !flush_o;

    always_comb begin
        stateNext = stateReg;
        countNext = countReg;
        wordNext  = NOP_ZERO;
        brEqNext  = brEqReg;
        taken     = 1'b0;
        case (stateReg)
            RUN, BR_OUT: begin
                stateNext = RUN;
                if (accept) begin
                    wordNext = decWord;
                    if (opcode_i == 5'b10100 || opcode_i == 5'b10101) begin
                        stateNext = BR_RESOLVE;
                        brEqNext  = opcode_i[0];
                    end else if (opcode_i == 5'b10110 && MULT_CYCLES > 1) begin
                        stateNext = MUL_BUSY;
                        countNext = CNT_W'(MULT_CYCLES - 1);
                    end
                end
            end
            BR_RESOLVE: begin
                // bne is taken on "not equal" codes only; 11 never takes either branch.
                taken = brEqReg ? (flags_i == 2'b01) : (flags_i == 2'b00 || flags_i == 2'b10);
                wordNext.pcSel = taken ? 2'b10 : 2'b00;
                wordNext.flush = taken;
                stateNext      = BR_OUT;
            end
            MUL_BUSY: begin
                wordNext  = wordReg;
                countNext = countReg - CNT_W'(1);
                if (countReg == CNT_W'(1)) begin
                    wordNext.regWe = 1'b1;
                    stateNext      = RUN;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= RUN;
            countReg <= '0;
            wordReg  <= NOP_ZERO;
            brEqReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            countReg <= countNext;
            wordReg  <= wordNext;
            brEqReg  <= brEqNext;
        end
    end

    assign illegal_o       = wordReg.illegal;
    assign pc_sel_o        = wordReg.pcSel;
    assign sel_dir_reg_b_o = wordReg.selDirRegB;
    assign mux_val_a_o     = wordReg.valA;
    assign mux_val_b_o     = wordReg.valB;
    assign alu_code_o      = wordReg.alu;
    assign result_sel_o    = wordReg.resultSel;
    assign dir_write_sel_o = wordReg.dirWrite;
    assign dir_mem_sel_o   = wordReg.dirMem;
    assign dato_sel_o      = wordReg.dato;
    assign mem_we_o        = wordReg.memWe;
    assign reg_we_o        = wordReg.regWe;

endmodule

// File: doc/control_unit_seq.md
Name: control_unit_seq

Overview:
- Registered, stall-aware successor to the combinational decoder in the 32-bit processor's ID stage.
- Decodes a 5-bit opcode into the ID/EX control word and registers that word one cycle later.
- Owns a small FSM that resolves conditional branches, sequences multi-cycle multiplies, and generates stall/flush for the fetch/decode registers.
- Adds shift-right/rotate decode, illegal-opcode detection, and parametrised multiply latency.

Parameters:
- MULT_CYCLES, 3: EX cycles occupied by MULT; must be ≥1.
- ALU_W, 4: width of alu_code_o.
- FLUSH_ON_JUMP, 1: when 1, unconditional jump also pulses flush_o.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode_i  in  5  opcode of the instruction in ID.
- valid_i  in  1  opcode_i holds a real instruction.
- flags_i  in  2  EX-stage compare flags (01 = equal; 00/10 = not equal).
- stall_o  out  1  hold PC and IF/ID; opcode_i is not accepted.
- flush_o  out  1  squash IF/ID; the opcode presented this cycle is discarded.
- illegal_o  out  1  one-cycle pulse, undefined opcode accepted.
- pc_sel_o  out  2  00 = PC+1, 01 = jump target, 10 = branch target.
- sel_dir_reg_b_o, mux_val_a_o, mux_val_b_o  out  1 each  operand mux selects.
- alu_code_o  out  ALU_W  ALU operation.
- result_sel_o  out  2  writeback result mux.
- dir_write_sel_o, dir_mem_sel_o, dato_sel_o  out  1 each  address/data mux selects.
- mem_we_o, reg_we_o  out  1 each  memory / register-file write enables.

Behaviour:
- Acceptance: the opcode is accepted when valid_i & !stall_o & !flush_o.
- Latency: the control word for an accepted opcode appears on outputs at the next rising edge (1 cycle).
- Bubbles: a non-accepted cycle registers the NOP-zero word: all outputs 0 except dir_mem_sel_o = 1.
- Reset: outputs take the NOP-zero word, stall_o = flush_o = illegal_o = 0, FSM = RUN, multiply counter = 0.
- Decode words (fields not listed are 0):
  - ALU register ops: 00000 add/0011, 00010 sub/0100, 00100 cmp/0101, 00110 and/0000, 00111 or/0001, 01000 not/0110, 01001 xor/0010, 10000 shl/0111, 10001 shr/1001, 10010 rot/1010. All set result_sel = 10, dir_mem = 1, dato = 1, reg_we = 1.
  - Immediate forms 00001, 00011, 00101: same as their register form, plus val_b = 1.
  - Load 01010: result_sel = 11, reg_we = 1. Load immediate 01011: same plus val_a = 1.
  - Store 01100: sel_dir_reg_b = 1, dir_mem = 1, mem_we = 1. Store immediate 01101: same plus val_a = 1.
  - Move 01110: dir_mem = 1, dato = 1, reg_we = 1. Move immediate 01111: same plus val_a = 1.
  - Jump 10011: pc_sel = 01; flush_o = FLUSH_ON_JUMP in the same cycle.
  - Branch 10100 (bne) / 10101 (beq): sel_dir_reg_b = 1, alu = 0101, dir_mem = 1, dato = 1.
  - Mult 10110: alu = 1000, result_sel = 01, dir_write = 1, dir_mem = 1, dato = 1. reg_we is governed by the MUL_BUSY rule below.
  - NOP 10111: result_sel = 11, dir_write = 1, dir_mem = 1, dato = 1.
  - Any other opcode: NOP-zero word and illegal_o = 1 for one cycle.
- FSM states: RUN, BR_RESOLVE, BR_OUT, MUL_BUSY.
- RUN:
  - Accepting 10100/10101 goes to BR_RESOLVE; the branch opcode is latched.
  - Accepting 10110 with MULT_CYCLES > 1 goes to MUL_BUSY with count = MULT_CYCLES-1.
- BR_RESOLVE:
  - Outputs carry the branch word (compare executing in EX); stall_o = 1.
  - flags_i is sampled at the closing edge. Taken = (bne & flags ∈ {00,10}) | (beq & flags == 01). Go to BR_OUT.
- BR_OUT (one cycle):
  - Taken: NOP-zero word with pc_sel = 10 and flush_o = 1.
  - Not taken: NOP-zero word with pc_sel = 00 and flush_o = 0.
  - stall_o = 0; the opcode may be accepted only when not taken. Return to RUN.
- MUL_BUSY:
  - Mult word held, stall_o = 1; count decrements each cycle; return to RUN when count reaches 0.
- Multiply write enable: reg_we_o = 1 only in the final multiply cycle, so exactly one write occurs. With MULT_CYCLES = 1 that is the single output cycle, and no stall occurs.
- Stall timing: stall_o is combinational from the state (asserted in BR_RESOLVE and MUL_BUSY), so no accept happens in those cycles.
- Reset mid-operation: asynchronous return to RUN with NOP-zero outputs; the pending branch or multiply is dropped.
- valid_i = 0 while in RUN: bubble only, no state change.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle → outputs go to NOP-zero with dir_mem_sel_o = 1 immediately, without waiting for a clock edge. Release reset, then present 00001 valid → next cycle alu_code_o = 0011, mux_val_b_o = 1, reg_we_o = 1, result_sel_o = 10.
- beq taken: 10101 accepted, flags_i = 01 in BR_RESOLVE → stall_o = 1 for 1 cycle. Next cycle pc_sel_o = 10, flush_o = 1, and the opcode presented that cycle is not decoded.
- bne not taken: 10100 accepted, flags_i = 01 → BR_OUT shows pc_sel_o = 00, flush_o = 0. The following add is accepted in BR_OUT and its word appears 1 cycle later.
- Multiply: 10110 with MULT_CYCLES = 3 → stall_o high for 2 cycles, reg_we_o high only in the 3rd output cycle, result_sel_o = 01 throughout. Repeat with MULT_CYCLES = 1 → single cycle with reg_we_o = 1 and no stall.
- Illegal and extended opcodes: 11111 → illegal_o pulses for 1 cycle and the NOP-zero word is registered. 10001 → alu_code_o = 1001, reg_we_o = 1. 10010 → alu_code_o = 1010.
- Reset during MUL_BUSY: rst_n low for 1 cycle → stall_o = 0 and FSM = RUN. After release, a new add decodes normally with no stray reg_we_o.
